// File: rtl/fetch.sv
// Instruction fetch stage: PC, imem request, IF/ID register and a one-entry skid buffer.
// The skid buffer catches a word that arrives while decode is stalled.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        can_accept;
  logic [31:0] pc_inc;

  assign can_accept  = !valid_q || !stall;
  assign pc_inc      = pc_q + 32'd4;
  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == FETCH) && !reset;
  assign instruction = instr_q;
  assign pc_plus4    = pc4_q;
  assign instr_valid = valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    // A redirect wins over everything except reset; the skid word and any returning data are dropped.
    if (branch_taken) begin
      pc_d         = {branch_target[31:2], 2'b00};
      valid_d      = 1'b0;
      instr_d      = 32'd0;
      skid_instr_d = 32'd0;
      skid_pc4_d   = 32'd0;
      state_d      = FETCH;
    end else if (state_q == FETCH) begin
      if (imem_ready) begin
        pc_d = pc_inc;
        if (can_accept) begin
          instr_d = imem_rdata;
          pc4_d   = pc_inc;
          valid_d = 1'b1;
        end else begin
          skid_instr_d = imem_rdata;
          skid_pc4_d   = pc_inc;
          state_d      = HOLD;
        end
      end else if (!stall) begin
        valid_d = 1'b0;
        instr_d = 32'd0;
      end
    end else if (!stall) begin
      instr_d = skid_instr_q;
      pc4_d   = skid_pc4_q;
      valid_d = 1'b1;
      state_d = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
      instr_q      <= 32'd0;
      pc4_q        <= 32'd0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios with literal expectations plus a long random run
// checked every cycle against a queue-based model of the fetch stage.
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, imem_ready;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata, instruction, pc_plus4;
  logic        instr_valid;

  logic        reset2, imem_ready2;
  logic        imem_req2;
  logic [31:0] imem_addr2, imem_rdata2, instruction2, pc_plus42;
  logic        instr_valid2;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0000;
    if (a == 32'h4) return 32'h319E_0015;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata  = mem_fn(imem_addr);
  assign imem_rdata2 = mem_fn(imem_addr2);

  fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instruction(instruction),
    .pc_plus4(pc_plus4), .instr_valid(instr_valid)
  );

  fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset2), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready2), .imem_rdata(imem_rdata2), .instruction(instruction2),
    .pc_plus4(pc_plus42), .instr_valid(instr_valid2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Model: a PC, the IF/ID contents, and a queue of words fetched but not yet accepted by decode.
  logic [31:0] m_pc = 0, m_instr = 0, m_pc4 = 0;
  logic        m_v = 0;
  logic [63:0] skq[$];

  always @(posedge clk) begin
    logic [63:0] item;
    if (reset) begin
      m_pc = 32'h0; m_v = 0; m_instr = 0; m_pc4 = 0; skq.delete();
    end else if (branch_taken) begin
      m_pc = branch_target & 32'hFFFF_FFFC; m_v = 0; m_instr = 0; skq.delete();
    end else if (skq.size() > 0) begin
      if (!stall) begin
        item = skq.pop_front();
        m_instr = item[63:32]; m_pc4 = item[31:0]; m_v = 1;
      end
    end else if (imem_ready) begin
      item = {mem_fn(m_pc), m_pc + 32'd4};
      m_pc = m_pc + 32'd4;
      if (!m_v || !stall) begin
        m_instr = item[63:32]; m_pc4 = item[31:0]; m_v = 1;
      end else skq.push_back(item);
    end else if (!stall) begin
      m_v = 0; m_instr = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req",    imem_req, 32'(!reset && skq.size() == 0));
      chk("imem_addr",   imem_addr, m_pc);
      chk("instr_valid", instr_valid, 32'(m_v));
      chk("instruction", instruction, m_instr);
      chk("pc_plus4",    pc_plus4, m_pc4);
    end
  end

  task automatic cyc(input logic r, input logic st, input logic bt,
                     input logic [31:0] tgt, input logic rdy);
    #1;
    reset = r; stall = st; branch_taken = bt; branch_target = tgt; imem_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    reset = 1; stall = 0; branch_taken = 0; branch_target = 0; imem_ready = 0;
    reset2 = 1; imem_ready2 = 1;
    @(negedge clk);
    chk_en = 1'b1;
    cyc(1, 0, 0, 0, 0);
    chk("reset_valid", instr_valid, 0);
    chk("reset_instr", instruction, 0);
    chk("reset_req", imem_req, 0);
    chk("dut2_reset_addr", imem_addr2, 32'hFFFF_FFFC);

    // first fetches after reset; dut2 wraps from 0xFFFFFFFC
    reset2 = 0;
    cyc(0, 0, 0, 0, 1);
    chk("first_instr", instruction, 32'h0000_0000);
    chk("first_pc4", pc_plus4, 32'd4);
    chk("first_valid", instr_valid, 1);
    chk("dut2_pc4_wrap", pc_plus42, 32'h0);
    chk("dut2_addr_wrap", imem_addr2, 32'h0);
    chk("dut2_instr", instruction2, mem_fn(32'hFFFF_FFFC));
    reset2 = 1;
    cyc(0, 0, 0, 0, 1);
    chk("second_instr", instruction, 32'h319E_0015);
    chk("second_pc4", pc_plus4, 32'd8);

    // stall 3 cycles with ready high: one word goes to the skid
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 1);
      chk("stall_req", imem_req, 0);
      chk("stall_hold_instr", instruction, 32'h319E_0015);
      chk("stall_hold_addr", imem_addr, 32'd12);
    end
    cyc(0, 0, 0, 0, 1);
    chk("skid_instr", instruction, mem_fn(32'd8));
    chk("skid_pc4", pc_plus4, 32'd12);
    cyc(0, 0, 0, 0, 1);
    chk("resume_instr", instruction, mem_fn(32'd12));
    chk("resume_pc4", pc_plus4, 32'd16);

    // branch while holding a skid word
    cyc(0, 1, 0, 0, 1);
    chk("hold_req", imem_req, 0);
    cyc(0, 1, 1, 32'h0000_0043, 1);
    chk("br_valid", instr_valid, 0);
    chk("br_addr", imem_addr, 32'h40);
    cyc(0, 0, 0, 0, 0);
    chk("br_no_skid", instr_valid, 0);
    cyc(0, 0, 0, 0, 1);
    chk("br_target_instr", instruction, mem_fn(32'h40));

    // memory not ready for 4 cycles
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("wait_addr", imem_addr, 32'h44);
      chk("wait_valid", instr_valid, 0);
      chk("wait_instr", instruction, 0);
    end

    // reset coincident with branch and ready
    cyc(1, 0, 1, 32'h100, 1);
    chk("rstbr_addr", imem_addr, 32'h0);
    chk("rstbr_valid", instr_valid, 0);
    chk("rstbr_pc4", pc_plus4, 0);
    chk("rstbr_instr", instruction, 0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 31) == 0),
          ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom,
          ($urandom_range(0, 9) < 7));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
